// File: rtl/huffman_encode_ctrl.sv
// Block sequencer for a single Huffman encoder: buffers a symbol block, replays it as one
// contiguous data_enable burst, then captures the encoder's code-table dump into a readable table.
module huffman_encode_ctrl #(
  parameter int BIT_WIDTH      = 7,
  parameter int LENGTH_OF_DATA = 100,
  parameter int MAX_SYMBOL     = 255,
  parameter int TIMEOUT        = 65535
) (
  input  logic                   clock,
  input  logic                   rst,
  input  logic [BIT_WIDTH:0]     s_data,
  input  logic                   s_valid,
  input  logic                   s_last,
  output logic                   s_ready,
  output logic                   enc_rst,
  output logic [BIT_WIDTH:0]     enc_data_in,
  output logic                   enc_data_enable,
  input  logic [BIT_WIDTH:0]     enc_symbol,
  input  logic [3:0]             enc_length,
  input  logic [2*BIT_WIDTH+2:0] enc_code,
  input  logic                   enc_data_out_state,
  input  logic [7:0]             tbl_rd_addr,
  output logic [BIT_WIDTH:0]     tbl_rd_symbol,
  output logic [3:0]             tbl_rd_length,
  output logic [2*BIT_WIDTH+2:0] tbl_rd_code,
  output logic [8:0]             sym_count,
  output logic                   busy,
  output logic                   done,
  output logic                   err_overflow,
  output logic                   err_timeout
);

  localparam int CNT_W     = $clog2(LENGTH_OF_DATA + 1);
  localparam int TO_W      = $clog2(TIMEOUT + 1);
  localparam int TBL_DEPTH = MAX_SYMBOL + 1;
  localparam int TBL_AW    = $clog2(TBL_DEPTH);

  typedef enum logic [3:0] {
    S_IDLE,
    S_LOAD,
    S_ENC_RST,
    S_INIT_WAIT,
    S_FEED,
    S_WAIT_TBL,
    S_CAPTURE,
    S_DONE,
    S_ERR
  } state_t;

  state_t state_q, state_d;

  logic [CNT_W-1:0]  count_q, count_d;
  logic [CNT_W-1:0]  idx_q, idx_d;
  logic [TO_W-1:0]   wait_q, wait_d;
  logic              init_q, init_d;
  logic [8:0]        sym_count_q, sym_count_d;
  logic              err_ovf_q, err_ovf_d;
  logic              err_to_q, err_to_d;

  logic              buf_we;
  logic [CNT_W-1:0]  buf_waddr;
  logic              tbl_we;

  logic [BIT_WIDTH:0]     sym_buf    [LENGTH_OF_DATA];
  logic [BIT_WIDTH:0]     tbl_symbol [TBL_DEPTH];
  logic [3:0]             tbl_length [TBL_DEPTH];
  logic [2*BIT_WIDTH+2:0] tbl_code   [TBL_DEPTH];

  always_ff @(posedge clock) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      count_q     <= '0;
      idx_q       <= '0;
      wait_q      <= '0;
      init_q      <= 1'b0;
      sym_count_q <= '0;
      err_ovf_q   <= 1'b0;
      err_to_q    <= 1'b0;
    end else begin
      count_q     <= count_d;
      idx_q       <= idx_d;
      wait_q      <= wait_d;
      init_q      <= init_d;
      sym_count_q <= sym_count_d;
      err_ovf_q   <= err_ovf_d;
      err_to_q    <= err_to_d;
    end
  end

  // Block buffer and code table are plain storage; their contents are only meaningful via the counters.
  always_ff @(posedge clock) begin
    if (buf_we) begin
      sym_buf[buf_waddr] <= s_data;
    end
    if (tbl_we) begin
      tbl_symbol[sym_count_q[TBL_AW-1:0]] <= enc_symbol;
      tbl_length[sym_count_q[TBL_AW-1:0]] <= enc_length;
      tbl_code[sym_count_q[TBL_AW-1:0]]   <= enc_code;
    end
  end

  always_comb begin
    state_d         = state_q;
    count_d         = count_q;
    idx_d           = idx_q;
    wait_d          = wait_q;
    init_d          = init_q;
    sym_count_d     = sym_count_q;
    err_ovf_d       = err_ovf_q;
    err_to_d        = err_to_q;
    buf_we          = 1'b0;
    buf_waddr       = count_q;
    tbl_we          = 1'b0;
    s_ready         = 1'b0;
    enc_rst         = 1'b0;
    enc_data_enable = 1'b0;
    enc_data_in     = '0;
    busy            = 1'b1;
    done            = 1'b0;

    case (state_q)
      S_IDLE: begin
        busy    = 1'b0;
        s_ready = 1'b1;
        if (s_valid) begin
          buf_we      = 1'b1;
          buf_waddr   = '0;
          count_d     = CNT_W'(1);
          err_ovf_d   = 1'b0;
          err_to_d    = 1'b0;
          sym_count_d = '0;
          state_d     = s_last ? S_ENC_RST : S_LOAD;
        end
      end
      S_LOAD: begin
        s_ready = 1'b1;
        if (s_valid) begin
          // A full buffer means this symbol has nowhere to go, even if it carries s_last.
          if (count_q == CNT_W'(LENGTH_OF_DATA)) begin
            err_ovf_d = 1'b1;
            state_d   = S_ERR;
          end else begin
            buf_we  = 1'b1;
            count_d = count_q + CNT_W'(1);
            if (s_last) begin
              state_d = S_ENC_RST;
            end
          end
        end
      end
      S_ENC_RST: begin
        enc_rst = 1'b1;
        init_d  = 1'b0;
        state_d = S_INIT_WAIT;
      end
      S_INIT_WAIT: begin
        if (init_q) begin
          idx_d   = '0;
          state_d = S_FEED;
        end else begin
          init_d = 1'b1;
        end
      end
      S_FEED: begin
        enc_data_enable = 1'b1;
        enc_data_in     = sym_buf[idx_q];
        idx_d           = idx_q + CNT_W'(1);
        if (idx_q == count_q - CNT_W'(1)) begin
          wait_d  = '0;
          state_d = S_WAIT_TBL;
        end
      end
      S_WAIT_TBL: begin
        wait_d = wait_q + TO_W'(1);
        // The first high cycle of data_out_state is the dump header, so it only triggers the move.
        if (enc_data_out_state) begin
          state_d = S_CAPTURE;
        end else if (wait_q == TO_W'(TIMEOUT - 1)) begin
          err_to_d = 1'b1;
          state_d  = S_ERR;
        end
      end
      S_CAPTURE: begin
        if (enc_data_out_state) begin
          if (sym_count_q != 9'(TBL_DEPTH)) begin
            tbl_we      = 1'b1;
            sym_count_d = sym_count_q + 9'd1;
          end
        end else begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      S_ERR: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (rst) begin
      s_ready = 1'b0;
    end
  end

  assign tbl_rd_symbol = tbl_symbol[tbl_rd_addr];
  assign tbl_rd_length = tbl_length[tbl_rd_addr];
  assign tbl_rd_code   = tbl_code[tbl_rd_addr];
  assign sym_count     = sym_count_q;
  assign err_overflow  = err_ovf_q;
  assign err_timeout   = err_to_q;

endmodule

// File: tb/tb_huffman_encode_ctrl.sv
// Scoreboard bench for huffman_encode_ctrl with a behavioural encoder stub that dumps
// one table entry per distinct fed symbol after a header cycle.
module tb_huffman_encode_ctrl;

  typedef struct packed {
    logic [8:0]       cnt;
    logic [2:0][7:0]  sym;
    logic [2:0][3:0]  len;
    logic [2:0][16:0] code;
  } done_exp_t;

  logic        clock = 1'b0;
  logic        rst;
  logic [7:0]  s_data;
  logic        s_valid;
  logic        s_last;
  logic        s_ready;
  logic        enc_rst;
  logic [7:0]  enc_data_in;
  logic        enc_data_enable;
  logic [7:0]  enc_symbol;
  logic [3:0]  enc_length;
  logic [16:0] enc_code;
  logic        enc_data_out_state;
  logic [7:0]  tbl_rd_addr = '0;
  logic [7:0]  tbl_rd_symbol;
  logic [3:0]  tbl_rd_length;
  logic [16:0] tbl_rd_code;
  logic [8:0]  sym_count;
  logic        busy;
  logic        done;
  logic        err_overflow;
  logic        err_timeout;

  int n_checks    = 0;
  int n_fail      = 0;
  int done_pulses = 0;
  int rst_pulses  = 0;
  int burst_len   = 0;
  int rst_width   = 0;

  logic [7:0] exp_feed [$];
  int         exp_burst [$];
  done_exp_t  exp_done [$];

  logic       stub_mute = 1'b0;
  int         stub_phase;
  int         stub_n;
  int         stub_dly;
  int         stub_pos;
  bit         stub_seen;
  bit         stub_found;
  logic [7:0] stub_dist [128];

  always #5 clock = ~clock;

  huffman_encode_ctrl #(
    .TIMEOUT(20)
  ) dut (
    .clock              (clock),
    .rst                (rst),
    .s_data             (s_data),
    .s_valid            (s_valid),
    .s_last             (s_last),
    .s_ready            (s_ready),
    .enc_rst            (enc_rst),
    .enc_data_in        (enc_data_in),
    .enc_data_enable    (enc_data_enable),
    .enc_symbol         (enc_symbol),
    .enc_length         (enc_length),
    .enc_code           (enc_code),
    .enc_data_out_state (enc_data_out_state),
    .tbl_rd_addr        (tbl_rd_addr),
    .tbl_rd_symbol      (tbl_rd_symbol),
    .tbl_rd_length      (tbl_rd_length),
    .tbl_rd_code        (tbl_rd_code),
    .sym_count          (sym_count),
    .busy               (busy),
    .done               (done),
    .err_overflow       (err_overflow),
    .err_timeout        (err_timeout)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic failBound(input string name);
    n_checks++;
    n_fail++;
    $display("[TB] FAIL %s: got no event within the cycle bound, expected one", name);
  endtask

  task automatic pushDone(input logic [8:0] cnt, input logic [2:0][7:0] s,
                          input logic [2:0][3:0] l, input logic [2:0][16:0] c);
    done_exp_t e;
    e.cnt  = cnt;
    e.sym  = s;
    e.len  = l;
    e.code = c;
    exp_done.push_back(e);
  endtask

  // Offers one symbol after `gap` idle cycles and holds it until the handshake; returns at posedge+1.
  task automatic applyStimulus(input logic [7:0] d, input logic last, input int gap);
    bit ok;
    for (int g = 0; g < gap; g++) begin
      @(posedge clock);
      #1;
    end
    s_data  = d;
    s_valid = 1'b1;
    s_last  = last;
    ok      = 1'b0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clock);
      if (s_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) failBound("handshake");
    @(posedge clock);
    #1;
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic waitIdle(input string name);
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 400; k++) begin
      @(negedge clock);
      if (!busy) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) failBound(name);
    @(posedge clock);
    #1;
  endtask

  // Encoder stub: collects the fed burst, then drives a header cycle followed by one entry per distinct symbol.
  initial begin
    enc_data_out_state = 1'b0;
    enc_symbol         = '0;
    enc_length         = '0;
    enc_code           = '0;
    stub_phase         = 0;
    stub_n             = 0;
    stub_seen          = 1'b0;
    stub_dly           = 0;
    stub_pos           = 0;
    forever begin
      @(posedge clock);
      #1;
      if (rst || enc_rst) begin
        stub_phase         = enc_rst && !rst ? 1 : 0;
        stub_n             = 0;
        stub_seen          = 1'b0;
        enc_data_out_state = 1'b0;
      end else begin
        case (stub_phase)
          1: begin
            if (enc_data_enable) begin
              stub_seen  = 1'b1;
              stub_found = 1'b0;
              for (int i = 0; i < stub_n; i++) begin
                if (stub_dist[i] == enc_data_in) stub_found = 1'b1;
              end
              if (!stub_found && stub_n < 128) begin
                stub_dist[stub_n] = enc_data_in;
                stub_n++;
              end
            end else if (stub_seen) begin
              stub_phase = 2;
              stub_dly   = 2;
            end
          end
          2: begin
            if (stub_dly == 0) begin
              if (stub_mute) begin
                stub_phase = 0;
              end else begin
                stub_phase         = 3;
                stub_pos           = 0;
                enc_data_out_state = 1'b1;
                enc_symbol         = 8'hEE;
                enc_length         = 4'd0;
                enc_code           = '0;
              end
            end else begin
              stub_dly--;
            end
          end
          3: begin
            stub_pos++;
            if (stub_pos <= stub_n) begin
              enc_symbol = stub_dist[stub_pos-1];
              enc_length = (stub_pos == 1) ? 4'd1 : 4'(stub_pos - 1);
              enc_code   = 17'(stub_pos - 1);
            end else begin
              enc_data_out_state = 1'b0;
              stub_phase         = 0;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Monitor: pops expectations whenever the DUT presents feed symbols, burst ends, enc_rst pulses or done.
  always @(negedge clock) begin
    if (!rst) begin
      if (enc_data_enable) begin
        burst_len++;
        if (exp_feed.size() == 0) begin
          checkOutput("feed_unexpected_symbol", enc_data_in, 32'hFFFF_FFFF);
        end else begin
          checkOutput("feed_symbol", enc_data_in, exp_feed.pop_front());
        end
      end else if (burst_len > 0) begin
        if (exp_burst.size() == 0) begin
          checkOutput("feed_unexpected_burst", burst_len, 0);
        end else begin
          checkOutput("feed_burst_len", burst_len, exp_burst.pop_front());
        end
        burst_len = 0;
      end

      if (enc_rst) begin
        rst_width++;
      end else if (rst_width > 0) begin
        checkOutput("enc_rst_width", rst_width, 1);
        rst_pulses++;
        rst_width = 0;
      end

      if (done) begin
        done_exp_t ed;
        done_pulses++;
        if (exp_done.size() == 0) begin
          checkOutput("done_unexpected", 1, 0);
        end else begin
          ed = exp_done.pop_front();
          checkOutput("done_sym_count", sym_count, ed.cnt);
          for (int i = 0; i < 3 && i < int'(ed.cnt); i++) begin
            tbl_rd_addr = 8'(i);
            #1;
            checkOutput($sformatf("tbl%0d_symbol", i), tbl_rd_symbol, ed.sym[i]);
            checkOutput($sformatf("tbl%0d_length", i), tbl_rd_length, ed.len[i]);
            checkOutput($sformatf("tbl%0d_code", i), tbl_rd_code, ed.code[i]);
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got simulation still running, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bit ok;
    int elapsed;
    rst     = 1'b1;
    s_data  = '0;
    s_valid = 1'b0;
    s_last  = 1'b0;

    @(negedge clock);
    @(negedge clock);
    checkOutput("reset_s_ready_low", s_ready, 0);
    rst = 1'b0;
    @(negedge clock);
    checkOutput("reset_s_ready_idle", s_ready, 1);
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_done", done, 0);
    checkOutput("reset_sym_count", sym_count, 0);
    checkOutput("reset_err_overflow", err_overflow, 0);
    checkOutput("reset_err_timeout", err_timeout, 0);
    checkOutput("reset_enc_rst", enc_rst, 0);
    checkOutput("reset_enc_enable", enc_data_enable, 0);
    checkOutput("reset_enc_data_in", enc_data_in, 0);
    @(posedge clock);
    #1;

    $display("[TB] block AAAB");
    exp_feed.push_back(8'h41); exp_feed.push_back(8'h41);
    exp_feed.push_back(8'h41); exp_feed.push_back(8'h42);
    exp_burst.push_back(4);
    pushDone(9'd2, {8'h00, 8'h42, 8'h41}, {4'd0, 4'd1, 4'd1}, {17'd0, 17'd1, 17'd0});
    applyStimulus(8'h41, 1'b0, 0);
    applyStimulus(8'h41, 1'b0, 0);
    applyStimulus(8'h41, 1'b0, 0);
    applyStimulus(8'h42, 1'b1, 0);
    waitIdle("aaab_complete");

    $display("[TB] single-symbol block");
    exp_feed.push_back(8'h55);
    exp_burst.push_back(1);
    pushDone(9'd1, {8'h00, 8'h00, 8'h55}, {4'd0, 4'd0, 4'd1}, {17'd0, 17'd0, 17'd0});
    applyStimulus(8'h55, 1'b1, 0);
    waitIdle("single_complete");

    $display("[TB] gapped load");
    exp_feed.push_back(8'h10); exp_feed.push_back(8'h20);
    exp_feed.push_back(8'h30); exp_feed.push_back(8'h20);
    exp_burst.push_back(4);
    pushDone(9'd3, {8'h30, 8'h20, 8'h10}, {4'd2, 4'd1, 4'd1}, {17'd2, 17'd1, 17'd0});
    applyStimulus(8'h10, 1'b0, 2);
    applyStimulus(8'h20, 1'b0, 1);
    applyStimulus(8'h30, 1'b0, 3);
    applyStimulus(8'h20, 1'b1, 2);
    s_data  = 8'hFF;
    s_valid = 1'b1;
    s_last  = 1'b1;
    @(posedge clock);
    @(posedge clock);
    #1;
    s_valid = 1'b0;
    s_last  = 1'b0;
    waitIdle("gapped_complete");

    $display("[TB] overflow block");
    for (int i = 0; i < 101; i++) begin
      applyStimulus(8'(i), 1'b0, 0);
    end
    @(negedge clock);
    checkOutput("ovf_flag", err_overflow, 1);
    checkOutput("ovf_err_state_busy", busy, 1);
    @(negedge clock);
    checkOutput("ovf_back_to_idle", busy, 0);
    checkOutput("ovf_flag_sticky", err_overflow, 1);
    @(posedge clock);
    #1;
    exp_feed.push_back(8'h77); exp_feed.push_back(8'h78);
    exp_burst.push_back(2);
    pushDone(9'd2, {8'h00, 8'h78, 8'h77}, {4'd0, 4'd1, 4'd1}, {17'd0, 17'd1, 17'd0});
    applyStimulus(8'h77, 1'b0, 0);
    @(negedge clock);
    checkOutput("ovf_cleared", err_overflow, 0);
    @(posedge clock);
    #1;
    applyStimulus(8'h78, 1'b1, 0);
    waitIdle("post_ovf_complete");

    $display("[TB] timeout block");
    stub_mute = 1'b1;
    exp_feed.push_back(8'h01); exp_feed.push_back(8'h02);
    exp_burst.push_back(2);
    applyStimulus(8'h01, 1'b0, 0);
    applyStimulus(8'h02, 1'b1, 0);
    ok = 1'b0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clock);
      if (enc_data_enable) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) failBound("timeout_feed_start");
    ok = 1'b0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clock);
      if (!enc_data_enable) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) failBound("timeout_feed_end");
    elapsed = 0;
    while (!err_timeout && elapsed < 100) begin
      @(negedge clock);
      elapsed++;
    end
    checkOutput("timeout_latency", elapsed, 20);
    checkOutput("timeout_no_done", done_pulses, 4);
    @(negedge clock);
    checkOutput("timeout_back_to_idle", busy, 0);
    checkOutput("timeout_flag_sticky", err_timeout, 1);
    stub_mute = 1'b0;
    @(posedge clock);
    #1;

    $display("[TB] reset during capture");
    exp_feed.push_back(8'h10); exp_feed.push_back(8'h20); exp_feed.push_back(8'h30);
    exp_burst.push_back(3);
    applyStimulus(8'h10, 1'b0, 0);
    @(negedge clock);
    checkOutput("timeout_cleared", err_timeout, 0);
    @(posedge clock);
    #1;
    applyStimulus(8'h20, 1'b0, 0);
    applyStimulus(8'h30, 1'b1, 0);
    ok = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clock);
      if (enc_data_out_state) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) failBound("capture_header");
    @(negedge clock);
    @(negedge clock);
    checkOutput("capture_partial_count", sym_count, 1);
    rst = 1'b1;
    @(negedge clock);
    checkOutput("midrst_busy", busy, 0);
    checkOutput("midrst_sym_count", sym_count, 0);
    checkOutput("midrst_s_ready_low", s_ready, 0);
    rst = 1'b0;
    @(negedge clock);
    checkOutput("midrst_s_ready_idle", s_ready, 1);
    @(posedge clock);
    #1;

    $display("[TB] block after reset");
    exp_feed.push_back(8'h33); exp_feed.push_back(8'h44);
    exp_burst.push_back(2);
    pushDone(9'd2, {8'h00, 8'h44, 8'h33}, {4'd0, 4'd1, 4'd1}, {17'd0, 17'd1, 17'd0});
    applyStimulus(8'h33, 1'b0, 0);
    applyStimulus(8'h44, 1'b1, 0);
    waitIdle("post_rst_complete");
    repeat (3) @(negedge clock);

    checkOutput("total_done_pulses", done_pulses, 5);
    checkOutput("total_enc_rst_pulses", rst_pulses, 7);
    checkOutput("feed_queue_drained", exp_feed.size(), 0);
    checkOutput("burst_queue_drained", exp_burst.size(), 0);
    checkOutput("done_queue_drained", exp_done.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
